// File: rtl/dncnt_pkg.sv
// dncnt_pkg: shared width, constants and count type for the down-count timer
package dncnt_pkg;
  localparam int W = 16;
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONES = '1;
  typedef logic [W-1:0] cnt_t;
endpackage

// File: rtl/dncnt_timer_if.sv
// dncnt_timer_if: register-decode side of the timer; oneshot exists only with DNCNT_ONESHOT_EN
interface dncnt_timer_if;
  import dncnt_pkg::*;
  cnt_t din, pre_q, div_q;
  logic wr_pre, wr_div, run, irq;
`ifdef DNCNT_ONESHOT_EN
  logic oneshot;
  modport master(output din, wr_pre, wr_div, oneshot, input pre_q, div_q, run, irq);
  modport slave(input din, wr_pre, wr_div, oneshot, output pre_q, div_q, run, irq);
`else
  modport master(output din, wr_pre, wr_div, input pre_q, div_q, run, irq);
  modport slave(input din, wr_pre, wr_div, output pre_q, div_q, run, irq);
`endif
endinterface

// File: rtl/dncnts.sv
// dncnts: one-bit down-count slice; toggles on borrow-in, passes borrow when the bit is 0
module dncnts (
  input  logic sys_clk,
  input  logic res,
  input  logic d,
  input  logic ci,
  input  logic ld,
  output logic q,
  output logic co
);
  always_ff @(posedge sys_clk)
    q <= res ? 1'b0 : ld ? d : q ^ ci;
  assign co = ci & ~q;
endmodule

// File: rtl/dncnt_timer.sv
// dncnt_timer: prescaler cascaded into divider, both counting down, periodic irq pulse.
// Optional one-shot mode is enabled by defining DNCNT_ONESHOT_EN.
module dncnt_timer
  import dncnt_pkg::*;
(
  input  logic          sys_clk,
  input  logic          res,
  dncnt_timer_if.slave  bus
);
  cnt_t pre_reg, div_reg, pre_cnt, div_cnt, pre_d, div_d;
  logic [W:0] pre_b, div_b;
  logic en, pre_tick, term, pre_ld, div_ld;
`ifdef DNCNT_ONESHOT_EN
  logic armed;
  assign en = bus.run & (armed | ~bus.oneshot);
`else
  assign en = bus.run;
`endif
  assign bus.run = pre_reg != ZERO;
  // a borrow leaving the top slice means the count was zero: that is the tick, and ld reloads
  assign pre_b[0] = en & ~bus.wr_pre;
  assign pre_tick = pre_b[W];
  assign pre_ld   = bus.wr_pre | pre_tick;
  assign pre_d    = bus.wr_pre ? bus.din : pre_reg;
  assign div_b[0] = pre_tick & ~bus.wr_div;
  assign term     = div_b[W];
  assign div_ld   = bus.wr_div | term;
  assign div_d    = bus.wr_div ? bus.din : div_reg;
  for (genvar i = 0; i < W; i++) begin : g_s
    dncnts u_p (.sys_clk, .res, .d(pre_d[i]), .ci(pre_b[i]), .ld(pre_ld), .q(pre_cnt[i]), .co(pre_b[i+1]));
    dncnts u_d (.sys_clk, .res, .d(div_d[i]), .ci(div_b[i]), .ld(div_ld), .q(div_cnt[i]), .co(div_b[i+1]));
  end
  assign bus.pre_q = pre_cnt;
  assign bus.div_q = div_cnt;
  always_ff @(posedge sys_clk) begin
    if (res) begin
      pre_reg <= ZERO;
      div_reg <= ZERO;
      bus.irq <= 1'b0;
    end else begin
      if (bus.wr_pre) pre_reg <= bus.din;
      if (bus.wr_div) div_reg <= bus.din;
      bus.irq <= term;
    end
`ifdef DNCNT_ONESHOT_EN
    if (res) armed <= 1'b0;
    else if (bus.wr_div) armed <= 1'b1;
    else if (term & bus.oneshot) armed <= 1'b0;
`endif
  end
endmodule
